sm2_kdf: RTL and testbench
==========================

SM2_KDF -- requirements
Module: sm2_kdf

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port zin, input, 512 bits: shared-secret string Z, with bit 511 as the first message bit.
REQ-004 SHALL have port start, input, 1 bit: a single-cycle request, sampled only in IDLE.
REQ-005 SHALL have port klen, input, 32 bits: requested key length in bits, sampled with start.
REQ-006 SHALL have port kout, output, 1024 bits: derived key, left-aligned.
REQ-007 SHALL have port kout_valid, output, 1 bit: one-cycle pulse marking kout as new.

Function
REQ-008 SHALL implement the GM/T 0003 SM2 KDF:
- K = SM3(Z||ct1) || SM3(Z||ct2) || ..., truncated to klen bits.
- ct is a 32-bit big-endian counter starting at 1.
REQ-009 SHALL implement SM3 exactly as GM/T 0004:
- IV = 7380166F 4914B2B9 172442D7 DA8A0600 A96F30BC 163138AA E38DEE4D B0FB0E4E.
- Tj = 79CC4519 for j<16, and 7A879D8A for j>=16.
- FF, GG, P0 and P1 as per GM/T 0004.
- W0..W67 and W'0..W'63 expansion as per GM/T 0004.
- Feed-forward XOR V(i+1) = CF(V(i)) XOR V(i).
REQ-010 SHALL pad each 544-bit message Z||ct into two blocks:
- Block 1 = zin.
- Block 2 = {ct, 1'b1, 415'b0, 64'd544}.
REQ-011 SHALL compress block 1 once per request and hold the resulting chaining value V1.
REQ-012 SHALL compress block 2 from V1 separately for each counter value.
REQ-013 SHALL use one compression round per cycle, plus one feed-forward cycle, giving 65 cycles per block.
REQ-014 SHALL compute the block count n as ceil(klen_eff/256), where klen_eff = min(klen, 1024).
REQ-015 SHALL use this FSM:
- IDLE: on start, latch zin, klen_eff and ct=1, then go to BLK1.
- BLK1: 65 cycles, then go to BLK2.
- BLK2: 65 cycles; store digest ct in kout bits [1023-256(ct-1) -: 256].
- BLK2 exit: if ct<n, increment ct and stay in BLK2; otherwise go to DONE.
- DONE: one cycle; apply the truncation mask, pulse kout_valid, then return to IDLE.
REQ-016 SHALL zero kout bits [1023-klen_eff:0] in DONE, so only the top klen_eff bits may be non-zero.
REQ-017 SHALL assert kout_valid for exactly one cycle, in the cycle 65*(n+1)+2 clock edges after the edge that samples start.
REQ-018 SHALL hold kout stable from the kout_valid pulse until the next accepted start.
REQ-019 SHALL clear kout to zero when a new start is accepted.
REQ-020 SHALL ignore start while not in IDLE; the request in progress continues unaffected.
REQ-021 SHALL handle klen=0 as follows: skip BLK1 and BLK2, go IDLE to DONE, and pulse kout_valid 2 edges after start with kout all-zero.
REQ-022 SHALL clamp klen>1024 to 1024 (n=4, no error).
REQ-023 SHALL not depend on zin or klen after the edge that samples start.

Reset
REQ-024 SHALL, when rstn is low, asynchronously:
- Force the state to IDLE.
- Set kout=0 and kout_valid=0.
- Clear the counter, the chaining registers and the latched inputs to 0.
REQ-025 SHALL abort any operation in progress on reset without producing a kout_valid pulse.
REQ-026 SHALL, after rstn deasserts, accept start no earlier than the first rising edge with rstn high.

Verification
REQ-027 Full-width case:
- Stimulus: zin=64D20D27D0632957F8028C1E024F6B02EDF23102A566C932AE8BD613A8E865FE58D225ECA784AE300A81A2D48281A828E1CEDF11C4219099840265375077BF78, klen=1000.
- Response: kout_valid at edge 327; kout[1023:24] matches a software SM3-KDF model; kout[23:0]=0.
REQ-028 Short-key case:
- Stimulus: zin=0x1001...01 pattern, klen=0x205 (517).
- Response: n=3; valid at edge 262; kout[1023:507] matches the model; kout[506:0]=0.
REQ-029 Zero-length case:
- Stimulus: klen=0.
- Response: kout_valid at edge 2; kout=0.
REQ-030 Clamp case:
- Stimulus: klen=5000.
- Response: output identical to klen=1024 (n=4, valid at edge 327).
REQ-031 Busy and reset cases:
- start pulsed again mid-run with a different zin: ignored, first result unchanged.
- rstn pulsed low mid-run: kout=0, no kout_valid pulse, next start works normally.

Source files
------------

// File: rtl/sm2_kdf.sv
// SM2 key derivation function built around an iterative SM3 core (one round per cycle).
// Z is compressed once; the second (counter) block is then re-compressed from V1 for each ct.
module sm2_kdf (
    input  logic          clk,
    input  logic          rstn,
    input  logic [511:0]  zin,
    input  logic          start,
    input  logic [31:0]   klen,
    output logic [1023:0] kout,
    output logic          kout_valid
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BLK1 = 2'd1;
    localparam logic [1:0] ST_BLK2 = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [255:0] SM3_IV =
        256'h7380166F_4914B2B9_172442D7_DA8A0600_A96F30BC_163138AA_E38DEE4D_B0FB0E4E;
    localparam logic [31:0] T_LO = 32'h79CC4519;
    localparam logic [31:0] T_HI = 32'h7A879D8A;
    localparam logic [6:0]  RND_FF = 7'd64;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
    endfunction

    function automatic logic [31:0] ff_fn(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z, input logic hi);
        return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
    endfunction

    function automatic logic [31:0] gg_fn(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z, input logic hi);
        return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
    endfunction

    logic [1:0]    state_r;
    logic [6:0]    rnd_r;
    logic [2:0]    ct_r;
    logic [10:0]   klen_r;
    logic [255:0]  v1_r;
    logic [31:0]   st_r  [8];
    logic [31:0]   win_r [16];
    logic [1023:0] kout_r;
    logic          valid_r;

    logic [10:0]   klen_eff_s;
    logic [2:0]    n_s;
    logic [1023:0] mask_s;
    logic [255:0]  cur_s;
    logic [255:0]  base_s;
    logic [255:0]  cv_s;
    logic [2:0]    blk2_ct_s;
    logic [511:0]  blk2_s;
    logic [31:0]   rnd_st_s [8];
    logic [31:0]   w_new_s;

    // Request decoding: clamped key length, block count and truncation mask
    always_comb begin
        if (klen > 32'd1024) begin
            klen_eff_s = 11'd1024;
        end else begin
            klen_eff_s = klen[10:0];
        end
        n_s    = klen_r[10:8] + ((|klen_r[7:0]) ? 3'd1 : 3'd0);
        mask_s = ~({1024{1'b1}} >> klen_r);
    end

    // Feed-forward value and the counter block to load on the next block boundary
    always_comb begin
        cur_s = {st_r[0], st_r[1], st_r[2], st_r[3], st_r[4], st_r[5], st_r[6], st_r[7]};
        if (state_r == ST_BLK1) begin
            base_s    = SM3_IV;
            blk2_ct_s = ct_r;
        end else begin
            base_s    = v1_r;
            blk2_ct_s = ct_r + 3'd1;
        end
        cv_s   = cur_s ^ base_s;
        blk2_s = {29'd0, blk2_ct_s, 1'b1, 415'd0, 64'd544};
    end

    // One SM3 compression round plus the sliding-window message expansion
    always_comb begin
        logic        hi;
        logic [31:0] tj, a12, ss1, ss2, tt1, tt2;
        hi  = (rnd_r >= 7'd16);
        tj  = hi ? T_HI : T_LO;
        a12 = rotl(st_r[0], 5'd12);
        ss1 = rotl(a12 + st_r[4] + rotl(tj, rnd_r[4:0]), 5'd7);
        ss2 = ss1 ^ a12;
        tt1 = ff_fn(st_r[0], st_r[1], st_r[2], hi) + st_r[3] + ss2 + (win_r[0] ^ win_r[4]);
        tt2 = gg_fn(st_r[4], st_r[5], st_r[6], hi) + st_r[7] + ss1 + win_r[0];
        rnd_st_s[0] = tt1;
        rnd_st_s[1] = st_r[0];
        rnd_st_s[2] = rotl(st_r[1], 5'd9);
        rnd_st_s[3] = st_r[2];
        rnd_st_s[4] = p0(tt2);
        rnd_st_s[5] = st_r[4];
        rnd_st_s[6] = rotl(st_r[5], 5'd19);
        rnd_st_s[7] = st_r[6];
        // W[j+16] from the window holding W[j]..W[j+15]
        w_new_s = p1(win_r[0] ^ win_r[7] ^ rotl(win_r[13], 5'd15))
                  ^ rotl(win_r[3], 5'd7) ^ win_r[10];
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            rnd_r   <= 7'd0;
            ct_r    <= 3'd0;
            klen_r  <= 11'd0;
            v1_r    <= 256'd0;
            kout_r  <= 1024'd0;
            valid_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                st_r[i] <= 32'd0;
            end
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= 32'd0;
            end
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        kout_r <= 1024'd0;
                        klen_r <= klen_eff_s;
                        ct_r   <= 3'd1;
                        rnd_r  <= 7'd0;
                        for (int i = 0; i < 8; i++) begin
                            st_r[i] <= SM3_IV[255-32*i -: 32];
                        end
                        for (int i = 0; i < 16; i++) begin
                            win_r[i] <= zin[511-32*i -: 32];
                        end
                        if (klen_eff_s == 11'd0) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_BLK1;
                        end
                    end
                end
                ST_BLK1, ST_BLK2: begin
                    if (rnd_r != RND_FF) begin
                        rnd_r <= rnd_r + 7'd1;
                        for (int i = 0; i < 8; i++) begin
                            st_r[i] <= rnd_st_s[i];
                        end
                        for (int i = 0; i < 15; i++) begin
                            win_r[i] <= win_r[i+1];
                        end
                        win_r[15] <= w_new_s;
                    end else begin
                        rnd_r <= 7'd0;
                        for (int i = 0; i < 16; i++) begin
                            win_r[i] <= blk2_s[511-32*i -: 32];
                        end
                        if (state_r == ST_BLK1) begin
                            v1_r <= cv_s;
                            for (int i = 0; i < 8; i++) begin
                                st_r[i] <= cv_s[255-32*i -: 32];
                            end
                            state_r <= ST_BLK2;
                        end else begin
                            case (ct_r)
                                3'd1:    kout_r[1023:768] <= cv_s;
                                3'd2:    kout_r[767:512]  <= cv_s;
                                3'd3:    kout_r[511:256]  <= cv_s;
                                3'd4:    kout_r[255:0]    <= cv_s;
                                default: kout_r           <= kout_r;
                            endcase
                            if (ct_r < n_s) begin
                                ct_r <= ct_r + 3'd1;
                                for (int i = 0; i < 8; i++) begin
                                    st_r[i] <= v1_r[255-32*i -: 32];
                                end
                            end else begin
                                state_r <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    kout_r  <= kout_r & mask_s;
                    valid_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign kout       = kout_r;
    assign kout_valid = valid_r;

endmodule

// File: tb/tb_sm2_kdf.sv
// Randomised bench for sm2_kdf against a straightforward SM3/KDF reference model.
module tb_sm2_kdf;

    logic          clk;
    logic          rstn;
    logic [511:0]  zin;
    logic          start;
    logic [31:0]   klen;
    logic [1023:0] kout;
    logic          kout_valid;

    int n_checks = 0;
    int n_pass   = 0;

    sm2_kdf dut (
        .clk        (clk),
        .rstn       (rstn),
        .zin        (zin),
        .start      (start),
        .klen       (klen),
        .kout       (kout),
        .kout_valid (kout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            int w;
            w = 0;
            for (int i = 15; i >= 0; i--) begin
                if (obs[64*i +: 64] !== exp[64*i +: 64]) begin
                    w = i;
                    break;
                end
            end
            $display("FAIL %s: word %0d got %h want %h", tag, w, obs[64*w +: 64], exp[64*w +: 64]);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    function automatic logic [255:0] sm3_compress(input logic [255:0] v, input logic [511:0] blk);
        logic [31:0] w [68];
        logic [31:0] wp [64];
        logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t, fv, gv, x;
        for (int j = 0; j < 16; j++) w[j] = blk[511-32*j -: 32];
        for (int j = 16; j < 68; j++) begin
            x = w[j-16] ^ w[j-9] ^ rol(w[j-3], 15);
            w[j] = (x ^ rol(x, 15) ^ rol(x, 23)) ^ rol(w[j-13], 7) ^ w[j-6];
        end
        for (int j = 0; j < 64; j++) wp[j] = w[j] ^ w[j+4];
        {a, b, c, d, e, f, g, h} = v;
        for (int j = 0; j < 64; j++) begin
            t   = (j < 16) ? 32'h79CC4519 : 32'h7A879D8A;
            ss1 = rol(rol(a, 12) + e + rol(t, j), 7);
            ss2 = ss1 ^ rol(a, 12);
            fv  = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
            gv  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
            tt1 = fv + d + ss2 + wp[j];
            tt2 = gv + h + ss1 + w[j];
            d = c; c = rol(b, 9); b = a; a = tt1;
            h = g; g = rol(f, 19); f = e;
            e = tt2 ^ rol(tt2, 9) ^ rol(tt2, 17);
        end
        return {a, b, c, d, e, f, g, h} ^ v;
    endfunction

    // SM3 of a left-aligned message of up to 959 bits with standard padding
    function automatic logic [255:0] sm3_msg(input logic [1023:0] msg, input int bitlen);
        logic [1023:0] p;
        logic [255:0]  v;
        p = msg;
        for (int i = 0; i < 1024 - bitlen; i++) p[i] = 1'b0;
        p[1023 - bitlen] = 1'b1;
        v = 256'h7380166F_4914B2B9_172442D7_DA8A0600_A96F30BC_163138AA_E38DEE4D_B0FB0E4E;
        if (bitlen + 65 <= 512) begin
            p[575:512] = 64'(bitlen);
            v = sm3_compress(v, p[1023:512]);
        end else begin
            p[63:0] = 64'(bitlen);
            v = sm3_compress(v, p[1023:512]);
            v = sm3_compress(v, p[511:0]);
        end
        return v;
    endfunction

    function automatic int eff_len(input int unsigned kl);
        return (kl > 1024) ? 1024 : int'(kl);
    endfunction

    function automatic logic [1023:0] kdf_ref(input logic [511:0] z, input int unsigned kl);
        logic [1023:0] k;
        logic [31:0]   ctw;
        int ke, n;
        ke = eff_len(kl);
        n  = (ke + 255) / 256;
        k  = '0;
        for (int ct = 1; ct <= n; ct++) begin
            ctw = 32'(ct);
            k[1023 - 256*(ct-1) -: 256] = sm3_msg({z, ctw, 480'd0}, 544);
        end
        for (int i = 0; i < 1024 - ke; i++) k[i] = 1'b0;
        return k;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Issue one request; inject>0 pulses start again (with other data) at that cycle
    task automatic run_req(input logic [511:0] z, input int unsigned kl, input int inject,
                           input string tag);
        logic [1023:0] exp_k;
        logic [1023:0] got;
        int n, exp_lat, found;
        exp_k   = kdf_ref(z, kl);
        n       = (eff_len(kl) + 255) / 256;
        exp_lat = (n == 0) ? 2 : 65 * (n + 1) + 2;
        got     = '0;
        found   = -1;
        @(negedge clk);
        zin = z; klen = kl; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, "_clr"}, kout, 1024'd0);
            if (kout_valid) begin
                found = k;
                got   = kout;
                break;
            end
            zin   = rand512();
            klen  = $urandom;
            start = (k == inject);
        end
        start = 1'b0;
        check({tag, "_lat"}, 1024'(found), 1024'(exp_lat));
        check({tag, "_kout"}, got, exp_k);
        @(negedge clk);
        check({tag, "_pulse"}, 1024'(kout_valid), 1024'd0);
        repeat (3) @(negedge clk);
        check({tag, "_hold"}, kout, exp_k);
    endtask

    initial begin
        logic [511:0] zpat;
        int pulses;
        rstn = 1'b0; start = 1'b0; zin = '0; klen = '0;
        check("model_abc", 1024'(sm3_msg({24'h616263, 1000'd0}, 24)),
              1024'(256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0));
        repeat (3) @(negedge clk);
        check("rst_kout", kout, 1024'd0);
        check("rst_valid", 1024'(kout_valid), 1024'd0);
        rstn = 1'b1;

        run_req(512'h64D20D27D0632957F8028C1E024F6B02EDF23102A566C932AE8BD613A8E865FE58D225ECA784AE300A81A2D48281A828E1CEDF11C4219099840265375077BF78,
                1000, 0, "full");
        for (int i = 0; i < 32; i++) zpat[16*i +: 16] = 16'h1001;
        run_req(zpat, 517, 0, "short");
        run_req(rand512(), 0, 0, "zero");
        zpat = rand512();
        run_req(zpat, 5000, 0, "clamp5000");
        run_req(zpat, 1024, 0, "clamp1024");
        run_req(rand512(), 256, 0, "b256");
        run_req(rand512(), 257, 0, "b257");
        run_req(rand512(), 1, 0, "b1");
        run_req(rand512(), 700, 100, "busy");
        for (int i = 0; i < 4; i++) begin
            run_req(rand512(), $urandom_range(1, 1100), 0, "rand");
        end

        // Reset in the middle of a run
        @(negedge clk);
        zin = rand512(); klen = 900; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (150) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_kout", kout, 1024'd0);
        check("midrst_valid", 1024'(kout_valid), 1024'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (kout_valid) pulses++;
        end
        check("midrst_nopulse", 1024'(pulses), 1024'd0);
        check("midrst_idle_kout", kout, 1024'd0);
        run_req(rand512(), 768, 0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
